boron_inv_round_perm_iter: RTL and testbench
============================================

// Module: boron_inv_round_perm_iter
// PURPOSE
//  Inverse of the Boron round-permutation layer, used on the decryption path.
//  The 64-bit state is split into four 16-bit words. Each pass rotates each word RIGHT:
//   word0 by 1, word1 by 4, word2 by 7, word3 by 9.
//  This undoes the forward layer's left rotations.
//  Iterative and handshaked: accepts one block plus a pass count, applies one inverse pass
//  per clock, and holds the result until the consumer takes it.
// PARAMETERS
//  COUNT_W    4   width of in_count
//  MAX_COUNT  15  largest pass count honoured; larger requests are clamped to this value
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        in_data/in_count valid
//  in_ready   out  1        unit can accept a block (high only in IDLE)
//  in_data    in   64       ciphertext-side state: [15:0]=word0 ... [63:48]=word3
//  in_count   in   COUNT_W  number of inverse passes to apply (0 = pass-through)
//  out_valid  out  1        out_data holds the finished result
//  out_ready  in   1        consumer accepts out_data
//  out_data   out  64       state after in_count inverse passes
//  busy       out  1        high in BUSY or DONE
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is asynchronous and active-low (rst_n); all flops clear immediately.
//  - Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0,
//    out_data=0, busy=0, pass counter=0.
//  - Reset mid-operation drops the block. No partial output.
//  State machine (IDLE / BUSY / DONE)
//  - IDLE: in_ready=1. If in_valid=1 at an edge: load data_q<=in_data and
//    rem<=min(in_count, MAX_COUNT). Next state is BUSY if rem!=0, else DONE.
//  - BUSY: at each edge, data_q<=inv_pass(data_q) and rem<=rem-1.
//    Move to DONE on the edge where rem goes from 1 to 0.
//  - DONE: out_valid=1, out_data=data_q, stable while out_ready=0.
//    On out_valid&&out_ready, return to IDLE.
//  Timing and handshake
//  - A new block cannot be accepted in the same cycle as the output handshake
//    (in_ready=0 in DONE).
//  - Latency: with N effective passes, out_valid rises N+1 edges after the accept edge.
//    N=0 gives 1 edge.
//  - in_valid is ignored outside IDLE. Inputs are sampled only at the accept edge,
//    so later input changes have no effect.
//  Arithmetic
//  - Pure rotations, width-preserving; no carries.
//  - k passes are equivalent to rotate-right by (k*s mod 16) per word, where s is that
//    word's rotation. Therefore 16 passes is the identity.
//  - out_data is driven from data_q only; no combinational path from in_* to out_*.
// STRUCTURE
//  Shared package boron_pkg (also used by the forward permutation):
//  - WORD_W=16, BLOCK_W=64, N_WORDS=4
//  - ROT0=1, ROT1=4, ROT2=7, ROT3=9
//  - state encoding constants ST_IDLE, ST_BUSY, ST_DONE
//  Sub-module boron_inv_rot_word:
//  - parameters WORD_W and SHIFT; purely combinational rotate-right.
//  - Four instances form inv_pass(), fed from data_q.
//  Top level: FSM, rem counter, data_q register, clamp logic.
// TESTING
//  1. in_data=0x0001_0001_0001_0001, count=1 -> out_data=0x0080_0200_1000_8000,
//     out_valid 2 edges after accept.
//  2. in_data=0x0200_0080_0010_0002 (forward of test 1's input), count=1
//     -> 0x0001_0001_0001_0001 (round-trip).
//  3. in_data=0x0001_0001_0001_0001, count=2 -> 0x4000_0004_0100_4000, latency 3 edges.
//  4. count=0 with any data -> out_data==in_data after 1 edge.
//     count=16 -> identity after 16+1 edges (COUNT_W=5, MAX_COUNT=31 build).
//  5. Hold out_ready=0 for 10 cycles in DONE:
//     - out_data/out_valid stable, in_ready=0;
//     - in_valid pulses ignored;
//     - after the handshake, in_ready=1 the next cycle.
//  6. Assert rst_n=0 mid-BUSY (count=8, after 3 passes):
//     - out_valid=0 and in_ready=1 immediately;
//     - the next block processes correctly with no residue.
//     Also with default params, count=15 applied (a clamp check needs COUNT_W>4).

Source files
------------

// File: rtl/boron_pkg.sv
// boron_pkg: shared Boron permutation constants, word rotations and FSM encoding.
package boron_pkg;
  localparam int WORD_W = 16;
  localparam int BLOCK_W = 64;
  localparam int N_WORDS = 4;
  localparam int ROT0 = 1;
  localparam int ROT1 = 4;
  localparam int ROT2 = 7;
  localparam int ROT3 = 9;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  function automatic int rot_of(input int w);
    return w == 0 ? ROT0 : w == 1 ? ROT1 : w == 2 ? ROT2 : ROT3;
  endfunction
endpackage

// File: rtl/boron_inv_rot_word.sv
// boron_inv_rot_word: combinational rotate-right of one word by a fixed amount.
module boron_inv_rot_word #(
  parameter int WORD_W = 16,
  parameter int SHIFT = 1
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);
  assign y = (x >> SHIFT) | (x << (WORD_W - SHIFT));
endmodule

// File: rtl/boron_inv_round_perm_iter.sv
// boron_inv_round_perm_iter: iterative inverse Boron permutation layer, one pass per clock,
// with valid/ready handshakes on both sides.
module boron_inv_round_perm_iter
  import boron_pkg::*;
#(
  parameter int COUNT_W = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [COUNT_W-1:0] in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);
  state_t state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d, pass;
  logic [COUNT_W-1:0] rem_q, rem_d, clamp;
  for (genvar w = 0; w < N_WORDS; w++) begin : g_rot
    boron_inv_rot_word #(.WORD_W(WORD_W), .SHIFT(rot_of(w))) u_rot (
      .x(data_q[w*WORD_W +: WORD_W]),
      .y(pass[w*WORD_W +: WORD_W])
    );
  end
  assign clamp = (32'(in_count) > MAX_COUNT) ? COUNT_W'(MAX_COUNT) : in_count;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    rem_d = rem_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        data_d = in_data;
        rem_d = clamp;
        state_d = clamp != '0 ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        data_d = pass;
        rem_d = rem_q - COUNT_W'(1);
        state_d = rem_q == COUNT_W'(1) ? ST_DONE : ST_BUSY;
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      rem_q <= rem_d;
    end
  end
  assign in_ready = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign busy = state_q != ST_IDLE;
  assign out_data = data_q;
endmodule

// File: tb/tb_boron_inv_round_perm_iter.sv
// tb_boron_inv_round_perm_iter: directed checks on a default build, a COUNT_W=5/MAX=31 build
// and a COUNT_W=5/MAX=12 build that exercises the clamp.
module tb_boron_inv_round_perm_iter;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [63:0] in_data = '0;
  logic [4:0] in_count = '0;
  logic [2:0] ov, ir, bz;
  logic [63:0] od [3];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  boron_inv_round_perm_iter dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_count(in_count[3:0]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .busy(bz[0])
  );
  boron_inv_round_perm_iter #(.COUNT_W(5), .MAX_COUNT(31)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_count(in_count), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .busy(bz[1])
  );
  boron_inv_round_perm_iter #(.COUNT_W(5), .MAX_COUNT(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_count(in_count), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .busy(bz[2])
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [63:0] d, input int k);
    int sh [4] = '{1, 4, 7, 9};
    logic [15:0] w;
    for (int p = 0; p < k; p++)
      for (int i = 0; i < 4; i++) begin
        w = d[i*16 +: 16];
        d[i*16 +: 16] = (w >> sh[i]) | (w << (16 - sh[i]));
      end
    return d;
  endfunction
  task automatic wait_idle();
    for (int i = 0; i < 64 && ir != 3'b111; i++) begin
      @(posedge clk);
      #1;
    end
    chk("idle", 64'(ir), 64'h7);
  endtask
  task automatic run(input string tag, input int idx, input logic [63:0] d, input logic [4:0] c,
                     input logic [63:0] exp, input int exp_lat);
    int lat = 0;
    @(negedge clk);
    in_data = d;
    in_count = c;
    in_valid = 1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (i == 0) begin
        in_valid = 0;
        in_data = ~d;
        in_count = '1;
      end
      if (ov[idx]) break;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, od[idx], exp);
    wait_idle();
  endtask
  initial begin
    logic [63:0] held;
    #12;
    chk("rst_ov", 64'(ov), 64'h0);
    chk("rst_ir", 64'(ir), 64'h7);
    chk("rst_busy", 64'(bz), 64'h0);
    chk("rst_data", od[0], 64'h0);
    rst_n = 1;
    run("t1", 0, 64'h0001_0001_0001_0001, 1, 64'h0080_0200_1000_8000, 2);
    run("t2", 0, 64'h0200_0080_0010_0002, 1, 64'h0001_0001_0001_0001, 2);
    run("t3", 0, 64'h0001_0001_0001_0001, 2, 64'h4000_0004_0100_4000, 3);
    run("t4", 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'hDEAD_BEEF_CAFE_F00D, 1);
    run("t16", 1, 64'h0123_4567_89AB_CDEF, 16, 64'h0123_4567_89AB_CDEF, 17);
    run("t15", 0, 64'h0123_4567_89AB_CDEF, 15, model(64'h0123_4567_89AB_CDEF, 15), 16);
    run("t31", 1, 64'hF00D_1234_8000_0001, 31, model(64'hF00D_1234_8000_0001, 31), 32);
    run("clamp", 2, 64'hA5A5_3C3C_0F0F_1248, 20, model(64'hA5A5_3C3C_0F0F_1248, 12), 13);
    // hold the consumer off while the result sits in DONE
    out_ready = 0;
    @(negedge clk);
    in_data = 64'h0001_0001_0001_0001;
    in_count = 1;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    chk("t5_ov", 64'(ov[0]), 64'h1);
    held = od[0];
    chk("t5_data", held, 64'h0080_0200_1000_8000);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = 64'(i) * 64'h1111;
      in_count = 5'(i);
      @(negedge clk);
      if (od[0] !== held || ov[0] !== 1'b1 || ir[0] !== 1'b0 || bz[0] !== 1'b1) begin
        chk("t5_hold", {od[0][60:0], ov[0], ir[0], bz[0]}, {held[60:0], 3'b101});
        break;
      end
    end
    in_valid = 0;
    chk("t5_stable", od[0], held);
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("t5_ir_after", 64'(ir[0]), 64'h1);
    chk("t5_ov_after", 64'(ov[0]), 64'h0);
    wait_idle();
    // reset in the middle of an 8-pass job
    @(negedge clk);
    in_data = 64'h1357_9BDF_2468_ACE0;
    in_count = 8;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy", 64'(bz), 64'h7);
    rst_n = 0;
    #1;
    chk("t6_ov", 64'(ov), 64'h0);
    chk("t6_ir", 64'(ir), 64'h7);
    chk("t6_data", od[1], 64'h0);
    @(negedge clk);
    rst_n = 1;
    run("t6_next", 1, 64'h0200_0080_0010_0002, 1, 64'h0001_0001_0001_0001, 2);
    run("t6_next8", 0, 64'h1357_9BDF_2468_ACE0, 8, model(64'h1357_9BDF_2468_ACE0, 8), 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
